// File: rtl/out_uart_tx.sv
// OUT-instruction serial stage: a small word FIFO feeding an 8N1 transmitter.
// Each 16-bit word is sent as two bytes, high byte first.
module out_uart_tx #(
  parameter int CLKS_PER_BIT    = 104,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [15:0] i_data,
  output logic        o_full,
  output logic        o_busy,
  output logic        o_overflow,
  output logic        o_tx
);

  localparam int                       DEPTH     = 1 << FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_C   = (FIFO_ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [15:0]              LAST_TICK = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [15:0]                r_mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   r_count;
  logic                       r_overflow;

  state_t      r_state,   w_state_nx;
  logic [15:0] r_timer,   w_timer_nx;
  logic [15:0] r_shift,   w_shift_nx;
  logic [2:0]  r_bit_idx, w_bit_idx_nx;
  logic        r_byte_hi, w_byte_hi_nx;
  logic        r_tx,      w_tx_nx;

  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_tick;
  logic [7:0]  w_byte;

  assign w_full = (r_count == DEPTH_C);
  assign w_push = i_load && !w_full;
  assign w_pop  = (r_state == IDLE) && (r_count != '0);
  assign w_tick = (r_timer == LAST_TICK);
  assign w_byte = r_byte_hi ? r_shift[15:8] : r_shift[7:0];

  // NOTE: storage array has no reset; validity is tracked by pointers/count alone.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A write against a full FIFO is dropped even if a pop frees a slot this edge.
      if (i_load && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_byte_hi <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_timer   <= w_timer_nx;
      r_shift   <= w_shift_nx;
      r_bit_idx <= w_bit_idx_nx;
      r_byte_hi <= w_byte_hi_nx;
      r_tx      <= w_tx_nx;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches form.
    w_state_nx   = r_state;
    w_timer_nx   = r_timer + 16'd1;
    w_shift_nx   = r_shift;
    w_bit_idx_nx = r_bit_idx;
    w_byte_hi_nx = r_byte_hi;
    w_tx_nx      = r_tx;
    case (r_state)
      IDLE: begin
        w_timer_nx = '0;
        w_tx_nx    = 1'b1;
        if (w_pop) begin
          w_shift_nx   = r_mem[r_rd_ptr];
          w_byte_hi_nx = 1'b1;
          w_state_nx   = START;
          w_tx_nx      = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_timer_nx   = '0;
          w_bit_idx_nx = '0;
          w_state_nx   = DATA;
          w_tx_nx      = w_byte[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          w_timer_nx = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nx = STOP;
            w_tx_nx    = 1'b1;
          end else begin
            w_bit_idx_nx = r_bit_idx + 3'd1;
            w_tx_nx      = w_byte[r_bit_idx + 3'd1];
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_timer_nx = '0;
          if (r_byte_hi) begin
            // Low byte follows immediately with no idle gap.
            w_byte_hi_nx = 1'b0;
            w_state_nx   = START;
            w_tx_nx      = 1'b0;
          end else begin
            w_state_nx = IDLE;
            w_tx_nx    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_tx_nx    = 1'b1;
      end
    endcase
  end

  assign o_full     = w_full;
  assign o_busy     = (r_count != '0) || (r_state != IDLE);
  assign o_overflow = r_overflow;
  assign o_tx       = r_tx;

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: frame-level line model compared every cycle, a UART
// byte decoder, and directed scenarios with hand-computed expectations.
module tb_out_uart_tx;

  localparam int CPB   = 4;
  localparam int FAW   = 2;
  localparam int DEPTH = 1 << FAW;

  logic        clk;
  logic        i_reset;
  logic        i_load;
  logic [15:0] i_data;
  logic        o_full;
  logic        o_busy;
  logic        o_overflow;
  logic        o_tx;

  out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_WIDTH(FAW)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_load     (i_load),
    .i_data     (i_data),
    .o_full     (o_full),
    .o_busy     (o_busy),
    .o_overflow (o_overflow),
    .o_tx       (o_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model: word queue + 20-bit frame timeline
  logic [15:0] m_q[$];
  bit          m_active = 1'b0;
  int          m_t      = 0;
  logic [0:19] m_frame;
  bit          m_tx     = 1'b1;
  bit          m_ovf    = 1'b0;
  bit          m_valid  = 1'b0;
  bit          m_pop;
  bit          m_full_before;
  logic [15:0] m_word;

  function automatic logic [0:19] frame_of(input logic [15:0] w);
    logic [0:19] f;
    f[0]  = 1'b0;
    f[9]  = 1'b1;
    f[10] = 1'b0;
    f[19] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f[1 + i]  = w[8 + i];
      f[11 + i] = w[i];
    end
    return f;
  endfunction

  always @(posedge clk) begin
    m_valid = 1'b1;
    if (i_reset) begin
      m_q.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_tx     = 1'b1;
      m_ovf    = 1'b0;
    end else begin
      m_pop         = !m_active && (m_q.size() > 0);
      m_full_before = (m_q.size() == DEPTH);
      if (m_pop) begin
        m_word   = m_q.pop_front();
        m_frame  = frame_of(m_word);
        m_active = 1'b1;
        m_t      = 0;
        m_tx     = m_frame[0];
      end else if (m_active) begin
        m_t++;
        if (m_t == 20 * CPB) begin
          m_active = 1'b0;
          m_tx     = 1'b1;
        end else begin
          m_tx = m_frame[m_t / CPB];
        end
      end
      if (i_load) begin
        if (m_full_before) m_ovf = 1'b1;
        else               m_q.push_back(i_data);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_tx",   o_tx,       m_tx);
      check("model_full", o_full,     m_q.size() == DEPTH);
      check("model_busy", o_busy,     m_active || (m_q.size() > 0));
      check("model_ovf",  o_overflow, m_ovf);
    end
  end

  // ---------------- line decoder: mid-bit sampling of each 8N1 byte
  logic [7:0] dec_q[$];
  bit         dec_active = 1'b0;
  int         dec_cnt    = 0;
  logic [7:0] dec_byte;
  int         dec_idx;

  always @(negedge clk) begin
    if (i_reset) begin
      dec_active = 1'b0;
      dec_cnt    = 0;
    end else if (!dec_active) begin
      if (o_tx === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
      end
    end else begin
      dec_cnt++;
      if ((dec_cnt % CPB) == CPB / 2 && dec_cnt >= CPB) begin
        dec_idx = dec_cnt / CPB - 1;
        if (dec_idx < 8) begin
          dec_byte[dec_idx] = o_tx;
        end else begin
          check("stop_bit", o_tx, 1);
          dec_q.push_back(dec_byte);
          dec_active = 1'b0;
        end
      end
    end
  end

  task automatic check_bytes(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, dec_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dec_q.size(); i++)
      check(name, dec_q[i], exp[i]);
  endtask

  task automatic load_word(input logic [15:0] w);
    i_load = 1'b1;
    i_data = w;
    @(negedge clk);
    i_load = 1'b0;
  endtask

  task automatic load_pair(input logic [15:0] a, input logic [15:0] b);
    i_load = 1'b1;
    i_data = a;
    @(negedge clk);
    i_data = b;
    @(negedge clk);
    i_load = 1'b0;
    i_data = 16'hFFFF;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (o_busy !== 1'b0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", o_busy, 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    dec_q.delete();
  endtask

  logic [0:19] exp_bits;
  logic [7:0]  exp_q[$];

  initial begin
    i_reset = 1'b1;
    i_load  = 1'b0;
    i_data  = 16'h0000;

    // Reset then idle
    repeat (3) @(negedge clk);
    check("rst_tx",   o_tx,       1);
    check("rst_busy", o_busy,     0);
    check("rst_full", o_full,     0);
    check("rst_ovf",  o_overflow, 0);
    i_reset = 1'b0;
    repeat (50) begin
      @(negedge clk);
      check("idle_tx",   o_tx,   1);
      check("idle_busy", o_busy, 0);
    end

    // Single word 0xA55A: start, A5 LSB first, stop, start, 5A LSB first, stop
    dec_q.delete();
    exp_bits = 20'b0_10100101_1_0_01011010_1;
    load_word(16'hA55A);
    for (int k = 1; k <= 81; k++) begin
      @(negedge clk);
      if (k <= 80) check("a55a_bit", o_tx, exp_bits[(k - 1) / CPB]);
      if (k == 80) check("a55a_busy_last", o_busy, 1);
      if (k == 81) begin
        check("a55a_tx_end",   o_tx,   1);
        check("a55a_busy_end", o_busy, 0);
      end
    end
    exp_q = '{8'hA5, 8'h5A};
    check_bytes("a55a_bytes", exp_q);

    // Back-to-back words: one idle cycle between them
    dec_q.delete();
    load_pair(16'h0102, 16'h0304);
    for (int k = 2; k <= 82; k++) begin
      @(negedge clk);
      if (k == 80) check("b2b_stop",  o_tx, 1);
      if (k == 81) check("b2b_gap",   o_tx, 1);
      if (k == 82) check("b2b_start", o_tx, 0);
    end
    wait_idle(400);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_bytes("b2b_bytes", exp_q);

    // Reset during the high-byte data bits with two words queued
    dec_q.delete();
    load_pair(16'hC3C3, 16'h3C3C);
    repeat (4 + 3 * CPB) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check("midrst_tx",   o_tx,       1);
    check("midrst_busy", o_busy,     0);
    check("midrst_full", o_full,     0);
    check("midrst_ovf",  o_overflow, 0);
    i_reset = 1'b0;
    dec_q.delete();
    repeat (100) @(negedge clk);
    check("midrst_no_restart", dec_q.size(), 0);
    check("midrst_tx_idle",    o_tx,         1);

    // Overflow: six writes from IDLE, first is popped, five accepted
    do_reset();
    i_load = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i_data = 16'h1100 + 16'(i);
      @(negedge clk);
      if (i == 4) begin
        check("ovf_full_at5", o_full,     1);
        check("ovf_flag_at5", o_overflow, 0);
      end
      if (i == 5) begin
        check("ovf_full_at6", o_full,     1);
        check("ovf_flag_at6", o_overflow, 1);
      end
    end
    i_load = 1'b0;
    wait_idle(1000);
    check("ovf_sticky", o_overflow, 1);
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h11);
      exp_q.push_back(8'(i));
    end
    check_bytes("ovf_bytes", exp_q);

    // Write on the pop edge: one word queued as the FSM returns to IDLE
    do_reset();
    check("pop_ovf_cleared", o_overflow, 0);
    load_pair(16'h1234, 16'h5678);
    repeat (80) @(negedge clk);
    check("pop_idle_tx", o_tx, 1);
    i_load = 1'b1;
    i_data = 16'h9ABC;
    @(negedge clk);
    i_load = 1'b0;
    check("pop_full",        o_full,      0);
    check("pop_ovf",         o_overflow,  0);
    check("pop_busy",        o_busy,      1);
    check("pop_start",       o_tx,        0);
    check("pop_model_count", m_q.size(),  1);
    wait_idle(1000);
    exp_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    check_bytes("pop_bytes", exp_q);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
